// File: rtl/cv_copy_sequencer.sv
// VRAM->VRAM copy sequencer: pair/line counters, read issue and FIFO credits.
// Optional abort input enabled by defining CV_COPY_ABORT_EN.
module cv_copy_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CRD_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_srcX,
    input  logic [8:0]  cmd_srcY,
    input  logic [10:0] cmd_w,
    input  logic [9:0]  cmd_h,
`ifdef CV_COPY_ABORT_EN
    input  logic        abort,
`endif
    output logic        eng_active,
    output logic        eng_isWidthNot1,
    output logic        eng_xb0,
    output logic        eng_wb0,
    output logic        eng_canPush,
    output logic        eng_endVertical,
    output logic        eng_currLast,
    output logic        eng_nextLast,
    output logic        eng_readACK,
    input  logic [2:0]  eng_nextX,
    input  logic [2:0]  eng_nextY,
    input  logic        eng_read,
    input  logic        eng_push,
    input  logic        eng_exit,
    output logic        mem_rdReq,
    output logic [17:0] mem_rdAddr,
    input  logic        mem_rdGnt,
    input  logic        mem_rdValid,
    input  logic        fifo_pop,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } stateT;

    localparam logic [CRD_W-1:0] FULL = CRD_W'(FIFO_DEPTH);

    stateT             state;
    stateT             nextState;

    logic [9:0]        srcX;
    logic [8:0]        srcY;
    logic [10:0]       width;
    logic [9:0]        height;
    logic [10:0]       pairsPerLine;
    logic [10:0]       pairIdx;
    logic [9:0]        line;
    logic [CRD_W-1:0]  credits;
    logic              rdOutstanding;
    logic              rdReq;
    logic [17:0]       rdAddr;
    logic              readAck;
    logic              errReg;
    logic              doneReg;
    logic              dropRead;

    logic              abortHit;
    logic              inRun;
    logic              accept;
    logic              readFire;
    logic              readErr;
    logic              rdReturn;
    logic              pushOnly;
    logic              popOnly;
    logic              crdErr;
    logic [8:0]        pairX;
    logic [8:0]        rowAddr;
    logic [10:0]       lastIdx;
    logic [10:0]       pplNew;

`ifdef CV_COPY_ABORT_EN
    assign abortHit = abort && (state == RUN);
`else
    assign abortHit = 1'b0;
`endif

    assign inRun    = (state == RUN);
    assign accept   = (state == IDLE) && cmd_valid;
    assign readFire = inRun && eng_read && !abortHit && !rdOutstanding;
    assign readErr  = inRun && eng_read && rdOutstanding;
    assign rdReturn = rdOutstanding && mem_rdValid;
    assign pushOnly = eng_push && !fifo_pop;
    assign popOnly  = fifo_pop && !eng_push;
    assign crdErr   = (pushOnly && (credits == '0))
                    || (popOnly && (credits == FULL));

    // Pair count covers a leading odd pixel and rounds a trailing one up.
    assign pplNew  = ({10'd0, cmd_srcX[0]} + cmd_w + 11'd1) >> 1;
    assign pairX   = srcX[9:1] + pairIdx[8:0];
    assign rowAddr = srcY + line[8:0];
    assign lastIdx = pairsPerLine - 11'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (eng_exit || abortHit) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                if ((credits == FULL) && !rdOutstanding) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srcX         <= '0;
            srcY         <= '0;
            width        <= '0;
            height       <= '0;
            pairsPerLine <= '0;
            pairIdx      <= '0;
            line         <= '0;
        end else if (accept) begin
            srcX         <= cmd_srcX;
            srcY         <= cmd_srcY;
            width        <= cmd_w;
            height       <= cmd_h;
            pairsPerLine <= pplNew;
            pairIdx      <= '0;
            line         <= '0;
        end else if (inRun) begin
            case (eng_nextX)
                3'd1:    pairIdx <= pairIdx + 11'd1;
                3'd6:    pairIdx <= '0;
                default: pairIdx <= pairIdx;
            endcase
            case (eng_nextY)
                3'd4:    line <= line + 10'd1;
                default: line <= line;
            endcase
        end
    end

    // Address is frozen at strobe time so the counters may move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdReq         <= 1'b0;
            rdOutstanding <= 1'b0;
            rdAddr        <= '0;
            readAck       <= 1'b0;
            dropRead      <= 1'b0;
        end else begin
            if (readFire) begin
                rdReq         <= 1'b1;
                rdOutstanding <= 1'b1;
                rdAddr        <= {rowAddr, pairX};
            end else if (rdReq && mem_rdGnt) begin
                rdReq <= 1'b0;
            end
            if (rdReturn) begin
                rdOutstanding <= 1'b0;
            end
            readAck <= rdReturn && !dropRead;
            if (rdReturn) begin
                dropRead <= 1'b0;
            end else if (abortHit && rdOutstanding) begin
                dropRead <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= FULL;
            errReg  <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            if (pushOnly && (credits != '0)) begin
                credits <= credits - 1'b1;
            end else if (popOnly && (credits != FULL)) begin
                credits <= credits + 1'b1;
            end
            errReg  <= errReg | readErr | crdErr;
            doneReg <= (state == DRAIN) && (nextState == IDLE);
        end
    end

    assign cmd_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign done            = doneReg;
    assign err             = errReg;
    assign eng_active      = inRun;
    assign eng_isWidthNot1 = (width != 11'd1);
    assign eng_xb0         = srcX[0];
    assign eng_wb0         = width[0];
    // The push already in flight this cycle holds a credit.
    assign eng_canPush     = inRun && (credits > {{(CRD_W-1){1'b0}}, eng_push});
    assign eng_endVertical = (line == height - 10'd1);
    assign eng_currLast    = (pairIdx == lastIdx);
    assign eng_nextLast    = ((pairIdx + 11'd1) == lastIdx);
    assign eng_readACK     = readAck;
    assign mem_rdReq       = rdReq;
    assign mem_rdAddr      = rdAddr;

endmodule
